// File: rtl/upsampler.sv
// ============================================================================
// upsampler : expands each accepted sample into INTERPOLATION_RATIO outputs
//             (zero-stuffed or held) with ready handshake and overrun pulse.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module upsampler #(
   parameter int DATA_WIDTH          = 12,
   parameter int INTERPOLATION_RATIO = 4,
   parameter int HOLD_MODE           = 0
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic signed [DATA_WIDTH-1:0] data_in,
   input  logic                         dv_in,
   output logic                         ready,
   output logic signed [DATA_WIDTH-1:0] data_out,
   output logic                         dv,
   output logic                         first,
   output logic                         overrun
);

   localparam int                PHASE_WIDTH = $clog2(INTERPOLATION_RATIO);
   localparam logic [PHASE_WIDTH-1:0] C_LAST_PHASE = PHASE_WIDTH'(INTERPOLATION_RATIO - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t                         state_q,    state_d;
   logic [PHASE_WIDTH-1:0]         phase_q,    phase_d;
   logic signed [DATA_WIDTH-1:0]   hold_q,     hold_d;
   logic signed [DATA_WIDTH-1:0]   data_out_q, data_out_d;
   logic                           dv_q,       dv_d;
   logic                           first_q,    first_d;
   logic                           overrun_q,  overrun_d;

   logic                           w_last_phase;
   logic                           w_accept;
   logic signed [DATA_WIDTH-1:0]   w_fill;

   // Value driven on phases 1..R-1 of a burst.
   generate
      if (HOLD_MODE != 0) begin : g_hold
         assign w_fill = hold_q;
      end else begin : g_zero
         assign w_fill = '0;
      end
   endgenerate

   assign w_last_phase = (state_q == EMIT) && (phase_q == C_LAST_PHASE);
   assign ready        = (state_q == IDLE) || w_last_phase;
   assign w_accept     = dv_in && ready;

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      hold_d     = hold_q;
      data_out_d = data_out_q;
      dv_d       = 1'b0;
      first_d    = 1'b0;
      overrun_d  = dv_in && !ready;

      if (w_accept) begin
         state_d    = EMIT;
         phase_d    = '0;
         hold_d     = data_in;
         data_out_d = data_in;
         dv_d       = 1'b1;
         first_d    = 1'b1;
      end else if (state_q == EMIT) begin
         if (w_last_phase) begin
            // Burst complete with nothing waiting: data_out keeps its last value.
            state_d = IDLE;
            phase_d = '0;
         end else begin
            phase_d    = phase_q + 1'b1;
            data_out_d = w_fill;
            dv_d       = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         phase_q    <= '0;
         hold_q     <= '0;
         data_out_q <= '0;
         dv_q       <= 1'b0;
         first_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         hold_q     <= hold_d;
         data_out_q <= data_out_d;
         dv_q       <= dv_d;
         first_q    <= first_d;
         overrun_q  <= overrun_d;
      end
   end

   assign data_out = data_out_q;
   assign dv       = dv_q;
   assign first    = first_q;
   assign overrun  = overrun_q;

endmodule

`default_nettype wire
